axi_lite_arbiter_2to1: RTL and testbench
========================================

// Module: axi_lite_arbiter_2to1
//
// PURPOSE
// Shares one AXI4-Lite slave peripheral (e.g. gpio) between two AXI4-Lite masters,
// e.g. the core data port and the debug port. Round-robin arbitration, one transaction
// in flight at a time. Sits between the masters and the peripheral's axi port, with no
// address decoding. Downstream bresp/rresp pass through unmodified.
//
// PARAMETERS
// WIDTH       32  data width of all three AXI4-Lite ports
// ADDR_WIDTH  4   address width of all three ports (passed through unmodified)
//
// PORTS
// clk     input   1          clock; drives aclk of all three interfaces
// rst_n   input   1          async active-low reset; drives areset_n of all three interfaces
// axi_s0  axi4_lite  WIDTH   slave-side port for master 0 (subordinate modport)
// axi_s1  axi4_lite  WIDTH   slave-side port for master 1 (subordinate modport)
// axi_m   axi4_lite  WIDTH   master-side port to the shared peripheral (manager modport)
//
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous): state=IDLE, rr_last=1 (master 0 wins next tie),
//   aw_done=w_done=0. All valid/ready outputs drive 0 on every port. Data/addr/resp
//   outputs drive 0 when not granted. Outputs settle immediately, not at a clock edge.
// - Request from master i:
//   - wreq_i = awvalid & wvalid
//   - rreq_i = arvalid
//   - req_i  = wreq_i | rreq_i
//   - Within one master, write beats read.
// - States: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA. Grant index g is registered.
// - IDLE:
//   - Only one master requesting: grant it.
//   - Both requesting: grant ~rr_last.
//   - Go to WR_ADDR (wreq_g) or RD_ADDR. No channel is forwarded in IDLE.
//   - Latency: request seen at edge N -> axi_m.awvalid/arvalid high after edge N.
// - WR_ADDR:
//   - Forward s_g aw*/w* to axi_m.
//   - axi_m.awvalid = s_g.awvalid & ~aw_done
//   - axi_m.wvalid  = s_g.wvalid & ~w_done
//   - s_g.awready = axi_m.awready & ~aw_done; s_g.wready likewise.
//   - Set aw_done/w_done on each handshake. AW and W may complete in different cycles,
//     in either order.
//   - When both done (including the cycle the second completes) -> WR_RESP and clear
//     both flags.
// - WR_RESP:
//   - s_g.bvalid = axi_m.bvalid, s_g.bresp = axi_m.bresp, axi_m.bready = s_g.bready.
//   - On B handshake: rr_last=g -> IDLE.
// - RD_ADDR: forward ar*. On AR handshake -> RD_DATA.
// - RD_DATA:
//   - Forward rvalid/rdata/rresp to s_g, rready to axi_m.
//   - On R handshake: rr_last=g -> IDLE.
// - Non-granted master: every ready/valid output is 0, with no combinational path from
//   its inputs. It waits with valids held (AXI rule). Nothing is dropped.
// - Throughput: at most one transaction per 3 cycles for write or read. There is always
//   a 1-cycle IDLE bubble between transactions.
// - Master stalls (bready/rready low): state holds indefinitely, with no timeout and no
//   preemption.
// - Downstream responses arriving outside WR_RESP/RD_DATA: axi_m.bready/rready are 0,
//   so the response is not accepted.
// - Reset mid-transaction: abandon immediately and return to the reset state. The
//   downstream peripheral shares areset_n and resets too.
//
// TESTING (GPIO map: MODE=0x0, IDATA=0x4, ODATA=0x8)
// 1. s0 write ODATA=0xA5A5 alone.
//    -> axi_m sees awaddr=0x8 and wdata=0xA5A5; s0 gets bresp=OKAY.
//    -> All s1 ready/valid outputs stay 0 throughout.
// 2. After reset, s0 write MODE=0xFFFF and s1 read IDATA raised in the same cycle.
//    -> s0 completes first.
//    -> s1 arready stays 0 until 1 cycle after s0's B handshake, then s1 gets rdata=0xFFFF.
// 3. Both masters issue 4 back-to-back reads each.
//    -> Grant order is 0,1,0,1,0,1,0,1.
//    -> Each rdata is routed only to its requester.
// 4. Peripheral asserts awready 2 cycles before wready (stub slave).
//    -> axi_m.awvalid drops after the AW handshake.
//    -> Exactly one AW and one W handshake occur; one bvalid goes to the master.
// 5. s0 holds bready=0 for 5 cycles while s1 requests.
//    -> axi_m.bready=0 and the state holds.
//    -> s1 is not granted until 1 cycle after s0's B handshake.
// 6. rst_n dropped mid-cycle while in WR_RESP.
//    -> All valid/ready outputs read 0 before the next edge.
//    -> After release, simultaneous s0/s1 reads grant s0 first.

Source files
------------

// File: rtl/axi_lite_arbiter_2to1_if.sv
// AXI4-Lite bundle shared by both upstream masters and the downstream peripheral port.
// The subordinate modport is the peripheral-facing view; manager drives requests.
interface axi4_lite #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 4
) (
  input logic aclk,
  input logic areset_n
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH/8-1:0]    wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [WIDTH-1:0]      rdata;
  logic [1:0]            rresp;

  modport subordinate (
    input  aclk, areset_n,
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport manager (
    input  aclk, areset_n,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready
  );
endinterface

// File: rtl/axi_lite_arbiter_2to1.sv
// Round-robin 2:1 AXI4-Lite arbiter: one transaction in flight, grant held from request
// to response handshake, with a one-cycle IDLE bubble between transactions.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both
// high; valid never waits on ready, and a master keeps valid and payload stable until
// its transfer. Only the granted master ever sees a nonzero ready/valid.
module axi_lite_arbiter_2to1 #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  axi4_lite.subordinate       axi_s0,
  axi4_lite.subordinate       axi_s1,
  axi4_lite.manager           axi_m,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  state_t state, state_nx;
  logic   g, g_nx;
  logic   rr_last, rr_last_nx;
  logic   aw_done, aw_done_nx;
  logic   w_done, w_done_nx;

  // Inputs of the granted master, selected purely by the registered grant.
  logic                  sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
  logic [ADDR_WIDTH-1:0] sel_awaddr, sel_araddr;
  logic [2:0]            sel_awprot, sel_arprot;
  logic [WIDTH-1:0]      sel_wdata;
  logic [WIDTH/8-1:0]    sel_wstrb;

  assign sel_awvalid = g ? axi_s1.awvalid : axi_s0.awvalid;
  assign sel_awaddr  = g ? axi_s1.awaddr  : axi_s0.awaddr;
  assign sel_awprot  = g ? axi_s1.awprot  : axi_s0.awprot;
  assign sel_wvalid  = g ? axi_s1.wvalid  : axi_s0.wvalid;
  assign sel_wdata   = g ? axi_s1.wdata   : axi_s0.wdata;
  assign sel_wstrb   = g ? axi_s1.wstrb   : axi_s0.wstrb;
  assign sel_bready  = g ? axi_s1.bready  : axi_s0.bready;
  assign sel_arvalid = g ? axi_s1.arvalid : axi_s0.arvalid;
  assign sel_araddr  = g ? axi_s1.araddr  : axi_s0.araddr;
  assign sel_arprot  = g ? axi_s1.arprot  : axi_s0.arprot;
  assign sel_rready  = g ? axi_s1.rready  : axi_s0.rready;

  logic wreq0, wreq1, req0, req1;
  assign wreq0 = axi_s0.awvalid & axi_s0.wvalid;
  assign wreq1 = axi_s1.awvalid & axi_s1.wvalid;
  assign req0  = wreq0 | axi_s0.arvalid;
  assign req1  = wreq1 | axi_s1.arvalid;

  // Channel forwarding, all gated by state so nothing leaks in IDLE or under reset.
  logic                  m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [ADDR_WIDTH-1:0] m_awaddr, m_araddr;
  logic [2:0]            m_awprot, m_arprot;
  logic [WIDTH-1:0]      m_wdata;
  logic [WIDTH/8-1:0]    m_wstrb;
  logic                  s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]            s_bresp, s_rresp;
  logic [WIDTH-1:0]      s_rdata;

  always_comb begin
    m_awvalid = 1'b0;
    m_awaddr  = '0;
    m_awprot  = '0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_araddr  = '0;
    m_arprot  = '0;
    m_rready  = 1'b0;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = '0;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rresp   = '0;
    case (state)
      WR_ADDR: begin
        m_awvalid = sel_awvalid & ~aw_done;
        m_awaddr  = sel_awaddr;
        m_awprot  = sel_awprot;
        m_wvalid  = sel_wvalid & ~w_done;
        m_wdata   = sel_wdata;
        m_wstrb   = sel_wstrb;
        s_awready = axi_m.awready & ~aw_done;
        s_wready  = axi_m.wready & ~w_done;
      end
      WR_RESP: begin
        s_bvalid = axi_m.bvalid;
        s_bresp  = axi_m.bresp;
        m_bready = sel_bready;
      end
      RD_ADDR: begin
        m_arvalid = sel_arvalid;
        m_araddr  = sel_araddr;
        m_arprot  = sel_arprot;
        s_arready = axi_m.arready;
      end
      RD_DATA: begin
        s_rvalid = axi_m.rvalid;
        s_rdata  = axi_m.rdata;
        s_rresp  = axi_m.rresp;
        m_rready = sel_rready;
      end
      default: ;
    endcase
  end

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = m_awvalid & axi_m.awready;
  assign w_hs  = m_wvalid & axi_m.wready;
  assign b_hs  = s_bvalid & m_bready;
  assign ar_hs = m_arvalid & axi_m.arready;
  assign r_hs  = s_rvalid & m_rready;

  always_comb begin
    state_nx   = state;
    g_nx       = g;
    rr_last_nx = rr_last;
    aw_done_nx = aw_done;
    w_done_nx  = w_done;
    case (state)
      IDLE: begin
        if (req0 | req1) begin
          g_nx     = (req0 & req1) ? ~rr_last : req1;
          // Write wins over read within the same master.
          state_nx = (g_nx ? wreq1 : wreq0) ? WR_ADDR : RD_ADDR;
        end
      end
      WR_ADDR: begin
        if ((aw_done | aw_hs) & (w_done | w_hs)) begin
          state_nx   = WR_RESP;
          aw_done_nx = 1'b0;
          w_done_nx  = 1'b0;
        end else begin
          aw_done_nx = aw_done | aw_hs;
          w_done_nx  = w_done | w_hs;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          rr_last_nx = g;
          state_nx   = IDLE;
        end
      end
      RD_ADDR: begin
        if (ar_hs) state_nx = RD_DATA;
      end
      RD_DATA: begin
        if (r_hs) begin
          rr_last_nx = g;
          state_nx   = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      g       <= 1'b0;
      rr_last <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nx;
      g       <= g_nx;
      rr_last <= rr_last_nx;
      aw_done <= aw_done_nx;
      w_done  <= w_done_nx;
    end
  end

  assign dbg_state = state;

  assign axi_m.awvalid = m_awvalid;
  assign axi_m.awaddr  = m_awaddr;
  assign axi_m.awprot  = m_awprot;
  assign axi_m.wvalid  = m_wvalid;
  assign axi_m.wdata   = m_wdata;
  assign axi_m.wstrb   = m_wstrb;
  assign axi_m.bready  = m_bready;
  assign axi_m.arvalid = m_arvalid;
  assign axi_m.araddr  = m_araddr;
  assign axi_m.arprot  = m_arprot;
  assign axi_m.rready  = m_rready;

  assign axi_s0.awready = ~g & s_awready;
  assign axi_s0.wready  = ~g & s_wready;
  assign axi_s0.bvalid  = ~g & s_bvalid;
  assign axi_s0.bresp   = g ? 2'b00 : s_bresp;
  assign axi_s0.arready = ~g & s_arready;
  assign axi_s0.rvalid  = ~g & s_rvalid;
  assign axi_s0.rdata   = g ? '0 : s_rdata;
  assign axi_s0.rresp   = g ? 2'b00 : s_rresp;

  assign axi_s1.awready = g & s_awready;
  assign axi_s1.wready  = g & s_wready;
  assign axi_s1.bvalid  = g & s_bvalid;
  assign axi_s1.bresp   = g ? s_bresp : 2'b00;
  assign axi_s1.arready = g & s_arready;
  assign axi_s1.rvalid  = g & s_rvalid;
  assign axi_s1.rdata   = g ? s_rdata : '0;
  assign axi_s1.rresp   = g ? s_rresp : 2'b00;

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Bench for axi_lite_arbiter_2to1: two master drivers, a GPIO-like stub peripheral with
// tunable AW/W ready delays, and per-master expected-response queues.
module tb_axi_lite_arbiter_2to1;
  localparam int WIDTH = 32;
  localparam int AW    = 4;
  localparam int QW    = WIDTH + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4_lite #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) s0_if (.aclk(clk), .areset_n(rst_n));
  axi4_lite #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) s1_if (.aclk(clk), .areset_n(rst_n));
  axi4_lite #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) m_if  (.aclk(clk), .areset_n(rst_n));
  logic [2:0] dbg_state;

  axi_lite_arbiter_2to1 #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .axi_s0    (s0_if),
    .axi_s1    (s1_if),
    .axi_m     (m_if),
    .dbg_state (dbg_state)
  );

  // ---------------- master-side drive / observe ----------------
  logic             awvalid_d[2], wvalid_d[2], bready_d[2], arvalid_d[2], rready_d[2];
  logic [AW-1:0]    awaddr_d[2], araddr_d[2];
  logic [WIDTH-1:0] wdata_d[2];
  logic             awready_o[2], wready_o[2], bvalid_o[2], arready_o[2], rvalid_o[2];
  logic [1:0]       bresp_o[2], rresp_o[2];
  logic [WIDTH-1:0] rdata_o[2];

  assign s0_if.awvalid = awvalid_d[0];  assign s1_if.awvalid = awvalid_d[1];
  assign s0_if.awaddr  = awaddr_d[0];   assign s1_if.awaddr  = awaddr_d[1];
  assign s0_if.awprot  = 3'b000;        assign s1_if.awprot  = 3'b000;
  assign s0_if.wvalid  = wvalid_d[0];   assign s1_if.wvalid  = wvalid_d[1];
  assign s0_if.wdata   = wdata_d[0];    assign s1_if.wdata   = wdata_d[1];
  assign s0_if.wstrb   = 4'hF;          assign s1_if.wstrb   = 4'hF;
  assign s0_if.bready  = bready_d[0];   assign s1_if.bready  = bready_d[1];
  assign s0_if.arvalid = arvalid_d[0];  assign s1_if.arvalid = arvalid_d[1];
  assign s0_if.araddr  = araddr_d[0];   assign s1_if.araddr  = araddr_d[1];
  assign s0_if.arprot  = 3'b000;        assign s1_if.arprot  = 3'b000;
  assign s0_if.rready  = rready_d[0];   assign s1_if.rready  = rready_d[1];

  assign awready_o[0] = s0_if.awready;  assign awready_o[1] = s1_if.awready;
  assign wready_o[0]  = s0_if.wready;   assign wready_o[1]  = s1_if.wready;
  assign bvalid_o[0]  = s0_if.bvalid;   assign bvalid_o[1]  = s1_if.bvalid;
  assign bresp_o[0]   = s0_if.bresp;    assign bresp_o[1]   = s1_if.bresp;
  assign arready_o[0] = s0_if.arready;  assign arready_o[1] = s1_if.arready;
  assign rvalid_o[0]  = s0_if.rvalid;   assign rvalid_o[1]  = s1_if.rvalid;
  assign rdata_o[0]   = s0_if.rdata;    assign rdata_o[1]   = s1_if.rdata;
  assign rresp_o[0]   = s0_if.rresp;    assign rresp_o[1]   = s1_if.rresp;

  // ---------------- stub peripheral ----------------
  // MODE=0x0, IDATA=0x4 (reads back MODE), ODATA=0x8, 0xC answers SLVERR.
  logic [WIDTH-1:0] regs[4];
  logic             aw_got, w_got, st_bvalid, st_rvalid;
  logic [AW-1:0]    aw_addr_q;
  logic [WIDTH-1:0] w_data_q, st_rdata;
  logic [1:0]       st_bresp, st_rresp;
  int               aw_cnt, w_cnt;
  int               aw_wait = 0;
  int               w_wait = 0;

  assign m_if.awready = m_if.awvalid && !aw_got && (aw_cnt >= aw_wait);
  assign m_if.wready  = m_if.wvalid && !w_got && (w_cnt >= w_wait);
  assign m_if.arready = m_if.arvalid && !st_rvalid;
  assign m_if.bvalid  = st_bvalid;
  assign m_if.bresp   = st_bresp;
  assign m_if.rvalid  = st_rvalid;
  assign m_if.rdata   = st_rdata;
  assign m_if.rresp   = st_rresp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_got <= 1'b0;  w_got <= 1'b0;  aw_cnt <= 0;  w_cnt <= 0;
      st_bvalid <= 1'b0;  st_rvalid <= 1'b0;  st_bresp <= 2'b00;  st_rresp <= 2'b00;
      st_rdata <= '0;  aw_addr_q <= '0;  w_data_q <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (m_if.awvalid && m_if.awready) begin
        aw_got <= 1'b1;  aw_addr_q <= m_if.awaddr;  aw_cnt <= 0;
      end else if (m_if.awvalid) aw_cnt <= aw_cnt + 1;
      if (m_if.wvalid && m_if.wready) begin
        w_got <= 1'b1;  w_data_q <= m_if.wdata;  w_cnt <= 0;
      end else if (m_if.wvalid) w_cnt <= w_cnt + 1;
      if (aw_got && w_got) begin
        aw_got <= 1'b0;  w_got <= 1'b0;  st_bvalid <= 1'b1;
        st_bresp <= (aw_addr_q == 4'hC) ? 2'b10 : 2'b00;
        if (aw_addr_q != 4'hC) regs[aw_addr_q[3:2]] <= w_data_q;
      end else if (st_bvalid && m_if.bready) st_bvalid <= 1'b0;
      if (m_if.arvalid && m_if.arready) begin
        st_rvalid <= 1'b1;
        st_rresp  <= (m_if.araddr == 4'hC) ? 2'b10 : 2'b00;
        st_rdata  <= (m_if.araddr == 4'hC) ? 32'hDEAD_BEEF :
                     (m_if.araddr == 4'h4) ? regs[0] : regs[m_if.araddr[3:2]];
      end else if (st_rvalid && m_if.rready) st_rvalid <= 1'b0;
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0;
  int ar_cyc[2], b_cyc[2];
  int grant_log[$];
  int s1_act = 0, n_aw = 0, n_w = 0, n_b = 0, awv_viol = 0, wv_viol = 0, bready_viol = 0;
  logic [AW-1:0]    last_awaddr = '0;
  logic [WIDTH-1:0] last_wdata = '0;

  always @(negedge clk) begin
    cyc++;
    for (int m = 0; m < 2; m++) begin
      if (arvalid_d[m] && arready_o[m]) begin grant_log.push_back(m); ar_cyc[m] = cyc; end
      if (awvalid_d[m] && awready_o[m]) grant_log.push_back(m);
      if (bvalid_o[m] && bready_d[m]) b_cyc[m] = cyc;
    end
    if (awready_o[1] || wready_o[1] || bvalid_o[1] || arready_o[1] || rvalid_o[1]) s1_act++;
    if (m_if.awvalid && m_if.awready) begin n_aw++; last_awaddr = m_if.awaddr; end
    if (m_if.wvalid && m_if.wready) begin n_w++; last_wdata = m_if.wdata; end
    if (m_if.bvalid && m_if.bready) n_b++;
    if (m_if.awvalid && aw_got) awv_viol++;
    if (m_if.wvalid && w_got) wv_viol++;
    if (m_if.bready && !bready_d[0] && !bready_d[1]) bready_viol++;
  end

  // ---------------- scoreboard ----------------
  logic [QW-1:0]    exp_q0[$], exp_q1[$];
  logic [WIDTH-1:0] mdl[4];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int m, input logic [QW-1:0] e);
    if (m == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
  endtask

  task automatic pop_cmp(input int m, input string tag, input logic [QW-1:0] got);
    logic [QW-1:0] e;
    int sz;
    sz = (m == 0) ? exp_q0.size() : exp_q1.size();
    if (sz == 0) chk({tag, "_no_expect"}, 64'(got), 64'hFFFF_FFFF_FFFF_FFFF);
    else begin
      e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      chk(tag, 64'(got), 64'(e));
    end
  endtask

  function automatic logic [QW-1:0] exp_read(input logic [AW-1:0] a);
    if (a == 4'hC) return {2'b10, 32'hDEAD_BEEF};
    if (a == 4'h4) return {2'b00, mdl[0]};
    return {2'b00, mdl[a[3:2]]};
  endfunction

  task automatic mdl_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    if (a != 4'hC) mdl[a[3:2]] = d;
  endtask

  function automatic logic [14:0] quiet_vec();
    return {awready_o[0], wready_o[0], bvalid_o[0], arready_o[0], rvalid_o[0],
            awready_o[1], wready_o[1], bvalid_o[1], arready_o[1], rvalid_o[1],
            m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready};
  endfunction

  // ---------------- drivers ----------------
  task automatic clear_drive();
    for (int m = 0; m < 2; m++) begin
      awvalid_d[m] = 1'b0; wvalid_d[m] = 1'b0; bready_d[m] = 1'b0;
      arvalid_d[m] = 1'b0; rready_d[m] = 1'b0;
      awaddr_d[m] = '0; araddr_d[m] = '0; wdata_d[m] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    clear_drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_txn(input int m, input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                        input int hold);
    logic aw_ok, w_ok, aw_hit, w_hit, got;
    int budget;
    push_exp(m, {(a == 4'hC) ? 2'b10 : 2'b00, 32'h0});
    awaddr_d[m] = a;  wdata_d[m] = d;  awvalid_d[m] = 1'b1;  wvalid_d[m] = 1'b1;
    aw_ok = 1'b0;  w_ok = 1'b0;  budget = 0;
    while (!(aw_ok && w_ok) && budget < 200) begin
      @(negedge clk);
      aw_hit = awvalid_d[m] && awready_o[m];
      w_hit  = wvalid_d[m] && wready_o[m];
      @(posedge clk);
      #1;
      if (aw_hit) begin awvalid_d[m] = 1'b0; aw_ok = 1'b1; end
      if (w_hit)  begin wvalid_d[m] = 1'b0;  w_ok = 1'b1;  end
      budget++;
    end
    if (!(aw_ok && w_ok)) chk($sformatf("m%0d_aw_w_timeout", m), 64'(budget), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_state", 64'(dbg_state), 64'd2);
      chk("hold_m_bready", 64'(m_if.bready), 64'd0);
      @(posedge clk);
      #1;
    end
    bready_d[m] = 1'b1;  got = 1'b0;  budget = 0;
    while (!got && budget < 200) begin
      @(negedge clk);
      if (bvalid_o[m]) begin
        got = 1'b1;
        pop_cmp(m, $sformatf("m%0d_bresp", m), {bresp_o[m], 32'h0});
      end
      @(posedge clk);
      #1;
      budget++;
    end
    bready_d[m] = 1'b0;
    if (!got) chk($sformatf("m%0d_b_timeout", m), 64'(budget), 64'd0);
  endtask

  task automatic rd_txn(input int m, input logic [AW-1:0] a, input logic [QW-1:0] e);
    logic ar_hit, got;
    int budget;
    push_exp(m, e);
    araddr_d[m] = a;  arvalid_d[m] = 1'b1;  rready_d[m] = 1'b1;
    got = 1'b0;  budget = 0;
    while (!got && budget < 200) begin
      @(negedge clk);
      ar_hit = arvalid_d[m] && arready_o[m];
      if (rvalid_o[m]) begin
        got = 1'b1;
        pop_cmp(m, $sformatf("m%0d_rdata", m), {rresp_o[m], rdata_o[m]});
      end
      @(posedge clk);
      #1;
      if (ar_hit) arvalid_d[m] = 1'b0;
      budget++;
    end
    rready_d[m] = 1'b0;
    arvalid_d[m] = 1'b0;
    if (!got) chk($sformatf("m%0d_r_timeout", m), 64'(budget), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int s1_base, aw_base, w_base, b_base, awv_base, wv_base, brv_base, budget;
    logic aw_hit, w_hit;
    clear_drive();
    #1;
    chk("reset_quiet", 64'(quiet_vec()), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'd0);
    chk("reset_s0_rdata", 64'(rdata_o[0]), 64'd0);
    do_reset();

    // 1: lone s0 write
    s1_base = s1_act;
    mdl_write(4'h8, 32'hA5A5);
    wr_txn(0, 4'h8, 32'hA5A5, 0);
    chk("t1_awaddr", 64'(last_awaddr), 64'h8);
    chk("t1_wdata", 64'(last_wdata), 64'hA5A5);
    chk("t1_s1_quiet", 64'(s1_act - s1_base), 64'd0);

    // 2: simultaneous s0 write / s1 read after reset
    do_reset();
    mdl_write(4'h0, 32'hFFFF);
    fork
      wr_txn(0, 4'h0, 32'hFFFF, 0);
      rd_txn(1, 4'h4, exp_read(4'h4));
    join
    chk("t2_s1_ar_gap", 64'(ar_cyc[1] - b_cyc[0]), 64'd2);

    // 3: four back-to-back reads per master
    do_reset();
    mdl_write(4'h8, 32'h5A5A);
    wr_txn(0, 4'h8, 32'h5A5A, 0);
    mdl_write(4'h0, 32'h0F0F);
    wr_txn(1, 4'h0, 32'h0F0F, 0);
    grant_log.delete();
    fork
      begin for (int i = 0; i < 4; i++) rd_txn(0, 4'h8, exp_read(4'h8)); end
      begin for (int j = 0; j < 4; j++) rd_txn(1, 4'h0, exp_read(4'h0)); end
    join
    chk("t3_grant_count", 64'(grant_log.size()), 64'd8);
    for (int i = 0; i < grant_log.size() && i < 8; i++)
      chk($sformatf("t3_grant_%0d", i), 64'(grant_log[i]), 64'(i % 2));

    // 4: AW and W handshakes in different cycles, both orders, plus SLVERR passthrough
    do_reset();
    aw_base = n_aw;  w_base = n_w;  b_base = n_b;  awv_base = awv_viol;  wv_base = wv_viol;
    aw_wait = 0;  w_wait = 2;
    mdl_write(4'h8, 32'h1111);
    wr_txn(0, 4'h8, 32'h1111, 0);
    chk("t4_one_aw", 64'(n_aw - aw_base), 64'd1);
    chk("t4_one_w", 64'(n_w - w_base), 64'd1);
    chk("t4_one_b", 64'(n_b - b_base), 64'd1);
    aw_wait = 3;  w_wait = 0;
    wr_txn(1, 4'hC, 32'h2222, 0);
    aw_wait = 0;  w_wait = 0;
    chk("t4_aw_total", 64'(n_aw - aw_base), 64'd2);
    chk("t4_w_total", 64'(n_w - w_base), 64'd2);
    chk("t4_awvalid_after_hs", 64'(awv_viol - awv_base), 64'd0);
    chk("t4_wvalid_after_hs", 64'(wv_viol - wv_base), 64'd0);
    rd_txn(0, 4'hC, exp_read(4'hC));
    rd_txn(1, 4'h8, exp_read(4'h8));

    // 5: s0 stalls bready while s1 waits
    do_reset();
    brv_base = bready_viol;
    mdl_write(4'h8, 32'h77);
    fork
      wr_txn(0, 4'h8, 32'h77, 5);
      rd_txn(1, 4'h8, exp_read(4'h8));
    join
    chk("t5_s1_ar_gap", 64'(ar_cyc[1] - b_cyc[0]), 64'd2);
    chk("t5_stray_bready", 64'(bready_viol - brv_base), 64'd0);

    // 6: reset dropped mid-cycle in WR_RESP
    do_reset();
    awaddr_d[0] = 4'h8;  wdata_d[0] = 32'h99;  awvalid_d[0] = 1'b1;  wvalid_d[0] = 1'b1;
    budget = 0;
    while (!m_if.bvalid && budget < 20) begin
      @(negedge clk);
      aw_hit = awready_o[0];
      w_hit  = wready_o[0];
      @(posedge clk);
      #1;
      if (aw_hit) awvalid_d[0] = 1'b0;
      if (w_hit)  wvalid_d[0] = 1'b0;
      budget++;
    end
    chk("t6_in_wr_resp", 64'(dbg_state), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_quiet", 64'(quiet_vec()), 64'd0);
    chk("t6_rst_state", 64'(dbg_state), 64'd0);
    clear_drive();
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    grant_log.delete();
    fork
      rd_txn(0, 4'h8, exp_read(4'h8));
      rd_txn(1, 4'h0, exp_read(4'h0));
    join
    chk("t6_grant_count", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() > 0) chk("t6_first_grant", 64'(grant_log[0]), 64'd0);

    chk("q0_drained", 64'(exp_q0.size()), 64'd0);
    chk("q1_drained", 64'(exp_q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
